rob_retire_queue: RTL and testbench

- Reorder buffer for the out-of-order core: the consuming end of the dispatch interface and the producing end of the retire interface.
- Accepts up to DISP_WIDTH in-order allocations per cycle and records completion from the execution pipes.
- Retires up to RETIRE_WIDTH completed entries per cycle, in program order.
- Raises a pipeline flush when the retiring head is a mispredicted branch or carries an exception.

---
 rtl/rob_retire_queue.sv | 183 ++++++++++++++++++
 tb/tb_rob_retire_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire_queue.sv
// rob_retire_queue: in-order retire reorder buffer with flush on mispredict/exception.
// Defining ROB_PERF_CNT_EN adds retired/full-stall/flush performance counters.
module rob_retire_queue #(
  parameter int NUM_ROB_ENTS = 64,
  parameter int DISP_WIDTH   = 2,
  parameter int RETIRE_WIDTH = 4,
  parameter int NUM_FUS      = 4,
  parameter int NUM_AREGS    = 32,
  parameter int NUM_PREGS    = 128,
  localparam int IW = $clog2(NUM_ROB_ENTS),
  localparam int AW = $clog2(NUM_AREGS),
  localparam int PW = $clog2(NUM_PREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DISP_WIDTH-1:0]      disp_valid,
  input  logic [DISP_WIDTH*AW-1:0]   disp_dst_areg,
  input  logic [DISP_WIDTH*PW-1:0]   disp_dst_preg,
  input  logic [DISP_WIDTH*32-1:0]   disp_pc,
  output logic                       disp_ready,
  output logic [DISP_WIDTH*IW-1:0]   disp_rob_idx,
  input  logic [NUM_FUS-1:0]         wb_valid,
  input  logic [NUM_FUS*IW-1:0]      wb_rob_idx,
  input  logic [NUM_FUS-1:0]         wb_exception,
  input  logic [NUM_FUS-1:0]         wb_br_mispred,
  output logic [RETIRE_WIDTH-1:0]    ret_valid,
  output logic [RETIRE_WIDTH*AW-1:0] ret_dst_areg,
  output logic [RETIRE_WIDTH*PW-1:0] ret_dst_preg,
  output logic [RETIRE_WIDTH*32-1:0] ret_pc,
  output logic                       flush,
  output logic                       flush_exc,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]                flush_pc,
  output logic [31:0]                perf_retired,
  output logic [31:0]                perf_full_stall,
  output logic [15:0]                perf_flushes
`else
  output logic [31:0]                flush_pc
`endif
);
  logic [IW:0] head, tail, count, head_next, n_disp, n_ret;
  logic [NUM_ROB_ENTS-1:0] valid, complete, exc, mispred;
  logic [AW-1:0] e_areg [NUM_ROB_ENTS];
  logic [PW-1:0] e_preg [NUM_ROB_ENTS];
  logic [31:0] e_pc [NUM_ROB_ENTS];
  logic [IW-1:0] ridx [RETIRE_WIDTH];
  logic [DISP_WIDTH-1:0] acc;
  logic [RETIRE_WIDTH-1:0] rv;
  logic take_flush, take_exc, stop;
  logic [31:0] take_pc;

  assign count = tail - head;
  assign disp_ready = (NUM_ROB_ENTS - 32'(count)) >= DISP_WIDTH;
  assign acc = (disp_ready && !take_flush) ? disp_valid : '0;
  assign head_next = head + n_ret;

  for (genvar j = 0; j < RETIRE_WIDTH; j++) begin : g_ridx
    assign ridx[j] = head[IW-1:0] + IW'(j);
  end

  always_comb begin
    n_disp = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      disp_rob_idx[i*IW +: IW] = tail[IW-1:0] + IW'(i);
      n_disp = n_disp + (IW+1)'(acc[i]);
    end
  end

  // A mispredicted branch retires and ends the group; an excepting entry never retires.
  always_comb begin
    rv = '0;
    n_ret = '0;
    stop = 1'b0;
    take_flush = 1'b0;
    take_exc = 1'b0;
    take_pc = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      if (!stop) begin
        if (!valid[ridx[j]] || !complete[ridx[j]]) begin
          stop = 1'b1;
        end else if (exc[ridx[j]]) begin
          stop = 1'b1;
          if (j == 0) begin
            take_flush = 1'b1;
            take_exc = 1'b1;
            take_pc = e_pc[ridx[j]];
          end
        end else begin
          rv[j] = 1'b1;
          n_ret = n_ret + 1'b1;
          if (mispred[ridx[j]]) begin
            stop = 1'b1;
            take_flush = 1'b1;
            take_pc = e_pc[ridx[j]];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      valid <= '0;
      complete <= '0;
      exc <= '0;
      mispred <= '0;
      ret_valid <= '0;
      ret_dst_areg <= '0;
      ret_dst_preg <= '0;
      ret_pc <= '0;
      flush <= 1'b0;
      flush_exc <= 1'b0;
      flush_pc <= '0;
    end else begin
      head <= head_next;
      ret_valid <= rv;
      flush <= take_flush;
      flush_exc <= take_exc;
      if (take_flush) flush_pc <= take_pc;
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
        ret_dst_areg[j*AW +: AW] <= rv[j] ? e_areg[ridx[j]] : '0;
        ret_dst_preg[j*PW +: PW] <= rv[j] ? e_preg[ridx[j]] : '0;
        ret_pc[j*32 +: 32] <= rv[j] ? e_pc[ridx[j]] : '0;
      end
      if (take_flush) begin
        tail <= head_next;
        valid <= '0;
        complete <= '0;
        exc <= '0;
        mispred <= '0;
      end else begin
        tail <= tail + n_disp;
        for (int k = 0; k < NUM_FUS; k++)
          if (wb_valid[k] && valid[wb_rob_idx[k*IW +: IW]]) begin
            complete[wb_rob_idx[k*IW +: IW]] <= 1'b1;
            exc[wb_rob_idx[k*IW +: IW]] <= wb_exception[k];
            mispred[wb_rob_idx[k*IW +: IW]] <= wb_br_mispred[k];
          end
        for (int j = 0; j < RETIRE_WIDTH; j++)
          if (rv[j]) begin
            valid[ridx[j]] <= 1'b0;
            complete[ridx[j]] <= 1'b0;
          end
        for (int i = 0; i < DISP_WIDTH; i++)
          if (acc[i]) begin
            valid[disp_rob_idx[i*IW +: IW]] <= 1'b1;
            complete[disp_rob_idx[i*IW +: IW]] <= 1'b0;
            exc[disp_rob_idx[i*IW +: IW]] <= 1'b0;
            mispred[disp_rob_idx[i*IW +: IW]] <= 1'b0;
          end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DISP_WIDTH; i++)
      if (acc[i]) begin
        e_areg[disp_rob_idx[i*IW +: IW]] <= disp_dst_areg[i*AW +: AW];
        e_preg[disp_rob_idx[i*IW +: IW]] <= disp_dst_preg[i*PW +: PW];
        e_pc[disp_rob_idx[i*IW +: IW]] <= disp_pc[i*32 +: 32];
      end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert ((disp_valid & (disp_valid + 1'b1)) == '0);
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired <= '0;
      perf_full_stall <= '0;
      perf_flushes <= '0;
    end else begin
      perf_retired <= perf_retired + 32'(n_ret);
      perf_full_stall <= perf_full_stall + 32'(|disp_valid && !disp_ready);
      perf_flushes <= perf_flushes + 16'(take_flush);
    end
  end
`endif
endmodule

// File: tb/tb_rob_retire_queue.sv
// tb_rob_retire_queue: directed checks of dispatch, in-order retire, flush and wrap.
module tb_rob_retire_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] disp_valid = '0;
  logic [9:0] disp_dst_areg = '0;
  logic [13:0] disp_dst_preg = '0;
  logic [63:0] disp_pc = '0;
  logic disp_ready;
  logic [11:0] disp_rob_idx;
  logic [3:0] wb_valid = '0;
  logic [23:0] wb_rob_idx = '0;
  logic [3:0] wb_exception = '0;
  logic [3:0] wb_br_mispred = '0;
  logic [3:0] ret_valid;
  logic [19:0] ret_dst_areg;
  logic [27:0] ret_dst_preg;
  logic [127:0] ret_pc;
  logic flush, flush_exc;
  logic [31:0] flush_pc;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rob_retire_queue dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_dst_areg(disp_dst_areg), .disp_dst_preg(disp_dst_preg),
    .disp_pc(disp_pc), .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
    .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_exception(wb_exception),
    .wb_br_mispred(wb_br_mispred), .ret_valid(ret_valid), .ret_dst_areg(ret_dst_areg),
    .ret_dst_preg(ret_dst_preg), .ret_pc(ret_pc), .flush(flush), .flush_exc(flush_exc),
    .flush_pc(flush_pc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = '0;
    wb_valid = '0;
    wb_rob_idx = '0;
    wb_exception = '0;
    wb_br_mispred = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // lane i: pc = pc0+4i, areg = pc[6:2], preg = pc[8:2]
  task automatic disp(input logic [1:0] v, input logic [31:0] pc0);
    disp_valid = v;
    for (int i = 0; i < 2; i++) begin
      disp_pc[i*32 +: 32] = pc0 + 32'(4 * i);
      disp_dst_areg[i*5 +: 5] = pc0[6:2] + 5'(i);
      disp_dst_preg[i*7 +: 7] = pc0[8:2] + 7'(i);
    end
    tick();
    disp_valid = '0;
  endtask

  task automatic wb(input int k, input logic [5:0] idx, input logic e, input logic m);
    wb_valid[k] = 1'b1;
    wb_rob_idx[k*6 +: 6] = idx;
    wb_exception[k] = e;
    wb_br_mispred[k] = m;
  endtask

  initial begin
    do_reset();
    chk("rst_ready", disp_ready, 1);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_exc", flush_exc, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_idx", disp_rob_idx, 12'h040);

    // basic: six entries, two writeback cycles
    disp(2'b11, 32'h100);
    disp(2'b11, 32'h108);
    disp(2'b11, 32'h110);
    chk("b_tail_idx", disp_rob_idx, 12'h1C6);
    for (int k = 0; k < 4; k++) wb(k, 6'(k), 1'b0, 1'b0);
    tick();
    idle();
    chk("b_no_ret_yet", ret_valid, 0);
    wb(0, 6'd4, 1'b0, 1'b0);
    wb(1, 6'd5, 1'b0, 1'b0);
    tick();
    idle();
    chk("b_ret4", ret_valid, 4'b1111);
    chk("b_pc0", ret_pc[31:0], 32'h100);
    chk("b_pc3", ret_pc[127:96], 32'h10C);
    chk("b_areg3", ret_dst_areg[19:15], 3);
    chk("b_preg2", ret_dst_preg[20:14], 7'h42);
    tick();
    chk("b_ret2", ret_valid, 4'b0011);
    chk("b_pc5", ret_pc[63:32], 32'h114);
    tick();
    chk("b_empty_ret", ret_valid, 0);
    chk("b_head", dut.head, 6);
    chk("b_tail", dut.tail, 6);

    // out-of-order completion; duplicate index, highest lane wins
    do_reset();
    disp(2'b11, 32'h100);
    disp(2'b11, 32'h108);
    wb(0, 6'd3, 1'b0, 1'b1);
    wb(1, 6'd2, 1'b0, 1'b0);
    wb(2, 6'd1, 1'b0, 1'b0);
    wb(3, 6'd3, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("o_blocked", ret_valid, 0);
    wb(0, 6'd0, 1'b0, 1'b0);
    tick();
    idle();
    chk("o_blocked2", ret_valid, 0);
    tick();
    chk("o_ret4", ret_valid, 4'b1111);
    chk("o_no_flush", flush, 0);
    chk("o_pc0", ret_pc[31:0], 32'h100);

    // full buffer
    do_reset();
    for (int c = 0; c < 31; c++) disp(2'b11, 32'h1000 + 32'(8 * c));
    chk("f_ready62", disp_ready, 1);
    disp(2'b11, 32'h10F8);
    chk("f_full", disp_ready, 0);
    chk("f_tail64", dut.tail, 64);
    for (int k = 0; k < 4; k++) wb(k, 6'(k), 1'b0, 1'b0);
    tick();
    idle();
    chk("f_still_full", disp_ready, 0);
    disp(2'b11, 32'h2000);
    chk("f_ret4", ret_valid, 4'b1111);
    chk("f_ready_back", disp_ready, 1);
    chk("f_drop_tail", dut.tail, 64);
    disp(2'b11, 32'h2000);
    chk("f_accept_idx", disp_rob_idx, 12'h0C2);

    // mispredict at idx 1
    do_reset();
    disp(2'b11, 32'h200);
    disp(2'b11, 32'h208);
    wb(0, 6'd0, 1'b0, 1'b0);
    wb(1, 6'd1, 1'b0, 1'b1);
    wb(2, 6'd2, 1'b0, 1'b0);
    wb(3, 6'd3, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("m_ret", ret_valid, 4'b0011);
    chk("m_flush", flush, 1);
    chk("m_exc", flush_exc, 0);
    chk("m_pc", flush_pc, 32'h204);
    chk("m_tail", dut.tail, 2);
    chk("m_new_idx", disp_rob_idx[5:0], 2);
    chk("m_ready", disp_ready, 1);
    disp(2'b01, 32'h300);
    chk("m_pulse", flush, 0);
    chk("m_ret_after", ret_valid, 0);
    chk("m_tail3", dut.tail, 3);

    // exception at head
    do_reset();
    disp(2'b11, 32'h400);
    wb(0, 6'd0, 1'b1, 1'b0);
    wb(1, 6'd1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("e_ret", ret_valid, 0);
    chk("e_flush", flush, 1);
    chk("e_exc", flush_exc, 1);
    chk("e_pc", flush_pc, 32'h400);
    chk("e_tail", dut.tail, 0);
    tick();
    chk("e_pulse", flush, 0);
    chk("e_exc_clr", flush_exc, 0);

    // wrap: advance head to 62, then retire 62,63,0,1 in one group
    do_reset();
    for (int c = 0; c < 31; c++) disp(2'b11, 32'h1000 + 32'(8 * c));
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 4; k++)
        if (4 * w + k < 62) wb(k, 6'(4 * w + k), 1'b0, 1'b0);
      tick();
      idle();
    end
    tick();
    tick();
    tick();
    chk("w_head62", dut.head, 62);
    chk("w_idx", disp_rob_idx, 12'hFFE);
    disp(2'b11, 32'h500);
    disp(2'b11, 32'h508);
    wb(0, 6'd62, 1'b0, 1'b0);
    wb(1, 6'd63, 1'b0, 1'b0);
    wb(2, 6'd0, 1'b0, 1'b0);
    wb(3, 6'd1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("w_ret4", ret_valid, 4'b1111);
    chk("w_pc0", ret_pc[31:0], 32'h500);
    chk("w_pc2", ret_pc[95:64], 32'h508);
    chk("w_head66", dut.head, 66);
    rst = 1'b1;
    #1;
    chk("w_async_ret", ret_valid, 0);
    chk("w_async_pc", ret_pc[63:0], 0);
    chk("w_async_head", dut.head, 0);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
